// File: rtl/stack_pkg.sv
// Shared types for the stack arbiter: FSM states, op encoding, width helpers.
package stack_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PUSH = 3'd1,
    S_POP  = 3'd2,
    S_RESP = 3'd3,
    S_REJ  = 3'd4
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/stack_arb_rr.sv
// Combinational round-robin picker: first set mask bit at or above ptr, mod N.
module stack_arb_rr
  import stack_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  always_comb begin
    int k;
    found = 1'b0;
    index = '0;
    k     = 0;
    // Walk downward so the lowest offset from ptr is assigned last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (mask[k]) begin
        found = 1'b1;
        index = IW'(k);
      end
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one LIFO stack between requesters.
// Optional STACK_ARB_REJECT_EN: grant-and-reject ineligible winners instead of stalling.
module stack_arbiter
  import stack_pkg::*;
#(
  parameter  int p_NUM_REQ     = 4,
  parameter  int p_STACK_DEPTH = 2,
  parameter  int p_DATA_WIDTH  = 8,
  localparam int IW = id_w(p_NUM_REQ),
  localparam int CW = cnt_w(p_STACK_DEPTH)
) (
  input  logic                              i_CLK,
  input  logic                              i_RST_N,
  input  logic [p_NUM_REQ-1:0]              i_REQ,
  input  logic [p_NUM_REQ-1:0]              i_OP,
  input  logic [p_NUM_REQ*p_DATA_WIDTH-1:0] i_WDATA,
  output logic [p_NUM_REQ-1:0]              o_GNT,
  output logic                              o_ERR,
  output logic                              o_RVALID,
  output logic [p_DATA_WIDTH-1:0]           o_RDATA,
  output logic [IW-1:0]                     o_RID,
  output logic [CW-1:0]                     o_COUNT,
  output logic                              o_FULL,
  output logic                              o_EMPTY,
  output logic                              o_STK_WRITE_REQUEST,
  output logic                              o_STK_READ_REQUEST,
  output logic [p_DATA_WIDTH-1:0]           o_STK_INPUT,
  input  logic [p_DATA_WIDTH-1:0]           i_STK_OUTPUT
);

  localparam int N = p_NUM_REQ;
  localparam int W = p_DATA_WIDTH;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, id_q, win;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N-1:0]    elig, mask, gnt_n;
  logic            found, win_ok;
  logic            wr_n, rd_n, rv_n, err_n;
  logic [W-1:0]    in_n;

  always_comb begin
    elig = '0;
    for (int k = 0; k < N; k++) begin
      elig[k] = i_REQ[k] &
        (((i_OP[k] == OP_PUSH) & ~o_FULL) |
         ((i_OP[k] == OP_POP) & ~o_EMPTY));
    end
  end

`ifdef STACK_ARB_REJECT_EN
  assign mask = i_REQ;
`else
  assign mask = elig;
`endif

  stack_arb_rr #(
    .N  (N),
    .IW (IW)
  ) u_rr (
    .mask  (mask),
    .ptr   (ptr),
    .found (found),
    .index (win)
  );

  assign win_ok = elig[win];

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          if (!win_ok) state_n = S_REJ;
          else if (i_OP[win] == OP_PUSH) state_n = S_PUSH;
          else state_n = S_POP;
        end
      end
      S_POP:                 state_n = S_RESP;
      S_PUSH, S_RESP, S_REJ: state_n = S_IDLE;
      default:               state_n = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_n = '0;
    if (state == S_IDLE && found) gnt_n[win] = 1'b1;
    wr_n = (state_n == S_PUSH);
    rd_n = (state_n == S_POP);
    rv_n = (state_n == S_RESP);
`ifdef STACK_ARB_REJECT_EN
    err_n = (state_n == S_REJ);
`else
    err_n = 1'b0;
`endif
    in_n = wr_n ? i_WDATA[int'(win)*W +: W] : '0;
    cnt_n = cnt;
    if (state == S_PUSH) cnt_n = cnt + CW'(1);
    else if (state == S_POP) cnt_n = cnt - CW'(1);
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state               <= S_IDLE;
      ptr                 <= '0;
      id_q                <= '0;
      cnt                 <= '0;
      o_FULL              <= 1'b0;
      o_EMPTY             <= 1'b1;
      o_GNT               <= '0;
      o_ERR               <= 1'b0;
      o_RVALID            <= 1'b0;
      o_RID               <= '0;
      o_STK_WRITE_REQUEST <= 1'b0;
      o_STK_READ_REQUEST  <= 1'b0;
      o_STK_INPUT         <= '0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      o_FULL              <= (cnt_n == CW'(p_STACK_DEPTH));
      o_EMPTY             <= (cnt_n == '0);
      o_GNT               <= gnt_n;
      o_ERR               <= err_n;
      o_RVALID            <= rv_n;
      o_STK_WRITE_REQUEST <= wr_n;
      o_STK_READ_REQUEST  <= rd_n;
      o_STK_INPUT         <= in_n;
      if (state == S_IDLE && found) begin
        ptr  <= (int'(win) == N - 1) ? '0 : win + IW'(1);
        id_q <= win;
      end
      if (rv_n) o_RID <= id_q;
    end
  end

  assign o_COUNT = cnt;
  // Stack word only arrives during RESP, so the data path is gated, not re-registered.
  assign o_RDATA = o_RVALID ? i_STK_OUTPUT : '0;

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: directed steps then random traffic vs a transaction model.
module tb_stack_arbiter;

  localparam int N = 4;
  localparam int D = 2;
  localparam int W = 8;
`ifdef STACK_ARB_REJECT_EN
  localparam bit REJ = 1'b1;
`else
  localparam bit REJ = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, op;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   o_GNT;
  logic           o_ERR, o_RVALID, o_FULL, o_EMPTY;
  logic [W-1:0]   o_RDATA, o_STK_INPUT, stk_out;
  logic [1:0]     o_RID, o_COUNT;
  logic           o_STK_WRITE_REQUEST, o_STK_READ_REQUEST;

  always #5 clk = ~clk;

  stack_arbiter #(
    .p_NUM_REQ     (N),
    .p_STACK_DEPTH (D),
    .p_DATA_WIDTH  (W)
  ) dut (
    .i_CLK               (clk),
    .i_RST_N             (rst_n),
    .i_REQ               (req),
    .i_OP                (op),
    .i_WDATA             (wdata),
    .o_GNT               (o_GNT),
    .o_ERR               (o_ERR),
    .o_RVALID            (o_RVALID),
    .o_RDATA             (o_RDATA),
    .o_RID               (o_RID),
    .o_COUNT             (o_COUNT),
    .o_FULL              (o_FULL),
    .o_EMPTY             (o_EMPTY),
    .o_STK_WRITE_REQUEST (o_STK_WRITE_REQUEST),
    .o_STK_READ_REQUEST  (o_STK_READ_REQUEST),
    .o_STK_INPUT         (o_STK_INPUT),
    .i_STK_OUTPUT        (stk_out)
  );

  // Attached stack macro: data valid the cycle after a read request.
  logic [W-1:0] mac[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac.delete();
      stk_out <= '0;
    end else begin
      if (o_STK_WRITE_REQUEST) mac.push_back(o_STK_INPUT);
      if (o_STK_READ_REQUEST) stk_out <= (mac.size() > 0) ? mac.pop_back() : '0;
    end
  end

  typedef struct {
    logic [N-1:0] gnt;
    logic         err, wr, rd, rv;
    logic [W-1:0] din, rdata;
    logic [1:0]   rid;
    int           cnt;
  } exp_t;

  exp_t         plan[$];
  logic [W-1:0] m_stk[$];
  int           m_cnt, m_ptr;
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t blank(input int c);
    exp_t e;
    e.gnt = '0; e.err = 0; e.wr = 0; e.rd = 0; e.rv = 0;
    e.din = '0; e.rdata = '0; e.rid = '0; e.cnt = c;
    return e;
  endfunction

  function automatic bit can_do(input int k);
    return req[k] && (op[k] ? (m_cnt < D) : (m_cnt > 0));
  endfunction

  // Transaction model: one op per decision, push = 2 cycles, pop = 3, reject = 2.
  task automatic decide();
    int w = -1;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (w < 0 && (can_do(k) || (REJ && req[k]))) w = k;
    end
    if (w < 0) begin
      plan.push_back(blank(m_cnt));
      return;
    end
    m_ptr = (w + 1) % N;
    e = blank(m_cnt);
    e.gnt = N'(1 << w);
    if (!can_do(w)) begin
      e.err = 1;
      plan.push_back(e);
      plan.push_back(blank(m_cnt));
    end else if (op[w]) begin
      e.wr = 1;
      e.din = wdata[w*W +: W];
      m_stk.push_back(e.din);
      plan.push_back(e);
      m_cnt++;
      plan.push_back(blank(m_cnt));
    end else begin
      e.rd = 1;
      plan.push_back(e);
      m_cnt--;
      e = blank(m_cnt);
      e.rv = 1;
      e.rdata = m_stk.pop_back();
      e.rid = 2'(w);
      plan.push_back(e);
      plan.push_back(blank(m_cnt));
    end
  endtask

  task automatic step();
    exp_t e;
    if (plan.size() == 0) decide();
    e = plan.pop_front();
    chk("gnt", o_GNT, e.gnt);
    chk("err", o_ERR, e.err);
    chk("stk_wr", o_STK_WRITE_REQUEST, e.wr);
    chk("stk_rd", o_STK_READ_REQUEST, e.rd);
    if (e.wr) chk("stk_in", o_STK_INPUT, e.din);
    chk("rvalid", o_RVALID, e.rv);
    if (e.rv) begin
      chk("rdata", o_RDATA, e.rdata);
      chk("rid", o_RID, e.rid);
    end
    chk("count", o_COUNT, e.cnt);
    chk("full", o_FULL, e.cnt == D);
    chk("empty", o_EMPTY, e.cnt == 0);
  endtask

  task automatic model_reset();
    plan.delete();
    m_stk.delete();
    m_cnt = 0;
    m_ptr = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    step();
    for (int k = 0; k < N; k++) if (o_GNT[k]) req[k] = 1'b0;
  endtask

  task automatic ask(input int k, input logic o, input logic [W-1:0] d);
    req[k] = 1'b1;
    op[k] = o;
    wdata[k*W +: W] = d;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    op = '0;
    wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_empty", o_EMPTY, 1);
    chk("rst_full", o_FULL, 0);
    chk("rst_count", o_COUNT, 0);
    chk("rst_gnt", o_GNT, 0);
    chk("rst_stk", {o_STK_WRITE_REQUEST, o_STK_READ_REQUEST}, 0);
    chk("rst_rvalid", o_RVALID, 0);
    rst_n = 1'b1;

    ask(0, 1'b1, 8'hA5);
    cycle();
    chk("t1_gnt", o_GNT, 4'b0001);
    chk("t1_wr", o_STK_WRITE_REQUEST, 1);
    chk("t1_in", o_STK_INPUT, 8'hA5);
    cycle();
    chk("t1_count", o_COUNT, 1);
    ask(0, 1'b0, 8'h00);
    cycle();
    chk("t2_rd", o_STK_READ_REQUEST, 1);
    cycle();
    chk("t2_rvalid", o_RVALID, 1);
    chk("t2_rdata", o_RDATA, 8'hA5);
    chk("t2_rid", o_RID, 0);
    cycle();
    chk("t2_count", o_COUNT, 0);

    ask(0, 1'b1, 8'h11);
    repeat (2) cycle();
    ask(0, 1'b1, 8'h22);
    repeat (2) cycle();
    chk("t3_full", o_FULL, 1);
    ask(2, 1'b1, 8'h33);
    ask(1, 1'b0, 8'h00);
    cycle();
    chk("t3_gnt_pop", o_GNT, 4'b0010);
    cycle();
    chk("t3_rdata", o_RDATA, 8'h22);
    chk("t3_rid", o_RID, 1);
    cycle();
    chk("t3_count", o_COUNT, 1);
    cycle();
    chk("t3_gnt_push", o_GNT, 4'b0100);
    cycle();

    repeat (2) begin
      ask(0, 1'b0, 8'h00);
      repeat (3) cycle();
    end
    chk("t4_empty", o_EMPTY, 1);
    ask(3, 1'b0, 8'h00);
    for (int c = 0; c < 20; c++) begin
      cycle();
`ifdef STACK_ARB_REJECT_EN
      if (c == 0) begin
        chk("t4_rej_gnt", o_GNT, 4'b1000);
        chk("t4_rej_err", o_ERR, 1);
      end
`else
      chk("t4_stall_gnt", o_GNT, 0);
`endif
      chk("t4_no_rd", o_STK_READ_REQUEST, 0);
    end
    chk("t4_count", o_COUNT, 0);
    req[3] = 1'b0;
    repeat (2) cycle();

    ask(0, 1'b1, 8'h44);
    repeat (2) cycle();
    ask(0, 1'b0, 8'h00);
    cycle();
    chk("t5_rd", o_STK_READ_REQUEST, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_count", o_COUNT, 0);
    chk("t5_empty", o_EMPTY, 1);
    chk("t5_rd_off", o_STK_READ_REQUEST, 0);
    model_reset();
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("t5_no_rvalid", o_RVALID, 0);
    end

    for (int c = 0; c < 600; c++) begin
      cycle();
      for (int k = 0; k < N; k++) begin
        if (!req[k] && $urandom_range(3) == 0)
          ask(k, 1'($urandom_range(1)), 8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
